// File: rtl/inert_seq.sv
// inert_seq: owns the SPI monarch on the inertial-sensor link. Waits out
// sensor power-up, writes the fixed configuration, then answers every
// synchronized data-ready interrupt with a ten-byte burst read and presents
// pitch/roll/yaw rates and X/Y acceleration together with a one-cycle vld.
module inert_seq #(
  parameter int INIT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] inert_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch,
  output logic [15:0] roll,
  output logic [15:0] yaw,
  output logic [15:0] ax,
  output logic [15:0] ay,
  output logic        vld
);

  // The cycle in which wrt is high is the SEND sub-phase of a transaction;
  // the WAIT states cover the remaining cycles until done.
  typedef enum logic [2:0] {
    S_INIT,
    S_CFG_SEND,
    S_CFG_WAIT,
    S_IDLE,
    S_RD_WAIT,
    S_VLD
  } state_t;

  localparam logic [16:0] INIT_LAST = 17'(INIT_CYCLES - 1);

  state_t        state_q;
  logic [16:0]   timer_q;
  logic [3:0]    idx_q;
  logic          int_ff1_q;
  logic          int_s_q;
  logic          wrt_q;
  logic          vld_q;
  logic [15:0]   cmd_q;
  // Low/high bytes of the first nine reads; newest byte enters at the top.
  logic [71:0]   shad_q;
  logic [15:0]   ptch_q, roll_q, yaw_q, ax_q, ay_q;

  // Only the returned register byte is meaningful; the upper half is ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, inert_data[15:8]};

  function automatic logic [15:0] cfg_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 16'h0D02;
      2'd1:    return 16'h1062;
      2'd2:    return 16'h1162;
      default: return 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [3:0] i);
    return {8'hA2 + {4'h0, i}, 8'h00};
  endfunction

  // Two-flop synchronizer for the asynchronous data-ready interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_ff1_q <= 1'b0;
      int_s_q   <= 1'b0;
    end else begin
      int_ff1_q <= INT;
      int_s_q   <= int_ff1_q;
    end
  end

  // Sequencer: power-up wait, configuration writes, burst reads and result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      timer_q <= '0;
      idx_q   <= '0;
      wrt_q   <= 1'b0;
      vld_q   <= 1'b0;
      cmd_q   <= '0;
      shad_q  <= '0;
      ptch_q  <= '0;
      roll_q  <= '0;
      yaw_q   <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
    end else begin
      wrt_q <= 1'b0;
      vld_q <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          timer_q <= timer_q + 17'd1;
          if (timer_q == INIT_LAST) begin
            idx_q   <= '0;
            state_q <= S_CFG_SEND;
          end
        end
        S_CFG_SEND: begin
          wrt_q   <= 1'b1;
          cmd_q   <= cfg_cmd(idx_q[1:0]);
          state_q <= S_CFG_WAIT;
        end
        S_CFG_WAIT: begin
          // done during the wrt cycle cannot belong to this transaction
          if (done && !wrt_q) begin
            if (idx_q == 4'd3) begin
              state_q <= S_IDLE;
            end else begin
              idx_q <= idx_q + 4'd1;
              wrt_q <= 1'b1;
              cmd_q <= cfg_cmd(idx_q[1:0] + 2'd1);
            end
          end
        end
        S_IDLE: begin
          if (int_s_q) begin
            idx_q   <= '0;
            wrt_q   <= 1'b1;
            cmd_q   <= rd_cmd(4'd0);
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (done && !wrt_q) begin
            shad_q <= {inert_data[7:0], shad_q[71:8]};
            if (idx_q == 4'd9) begin
              // all five readings load together from the shadow bytes
              ptch_q  <= shad_q[15:0];
              roll_q  <= shad_q[31:16];
              yaw_q   <= shad_q[47:32];
              ax_q    <= shad_q[63:48];
              ay_q    <= {inert_data[7:0], shad_q[71:64]};
              vld_q   <= 1'b1;
              state_q <= S_VLD;
            end else begin
              idx_q <= idx_q + 4'd1;
              wrt_q <= 1'b1;
              cmd_q <= rd_cmd(idx_q + 4'd1);
            end
          end
        end
        S_VLD: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign wrt  = wrt_q;
  assign cmd  = cmd_q;
  assign vld  = vld_q;
  assign ptch = ptch_q;
  assign roll = roll_q;
  assign yaw  = yaw_q;
  assign ax   = ax_q;
  assign ay   = ay_q;

endmodule

// File: tb/tb_inert_seq.sv
// Testbench for inert_seq: SPI monarch and sensor model with a transaction
// scoreboard, table-driven burst vectors, timing sequences and random bursts.
`timescale 1ns/1ps
module tb_inert_seq;
  localparam int INIT_N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        INT;
  logic        done;
  logic [15:0] inert_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch, roll, yaw, ax, ay;
  logic        vld;

  inert_seq #(.INIT_CYCLES(INIT_N)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .inert_data(inert_data),
    .wrt(wrt), .cmd(cmd), .ptch(ptch), .roll(roll), .yaw(yaw),
    .ax(ax), .ay(ay), .vld(vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] bytes;   // byte i (returned for address A2+i) at [8*i +: 8]
    logic [15:0] e_ptch;
    logic [15:0] e_roll;
    logic [15:0] e_yaw;
    logic [15:0] e_ax;
    logic [15:0] e_ay;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic        mon_done, stray_done;
  assign done = mon_done | stray_done;

  int          lat, cnt;
  logic [7:0]  cur_addr;
  logic [7:0]  rbytes [10];
  logic [7:0]  ret_b  [10];
  int          issued, delivered, last_done_cyc, next_wrt_due;
  logic        prev_wrt;
  logic [15:0] last_cmd;
  logic [15:0] held [5];
  logic        autoclr, reassert_on_yawh;
  logic        seen_wrt, seen_vld;
  logic [15:0] seen_cmd;
  logic [15:0] vld_vals [5];
  vec_t        vec [3];
  int          n, c4, v1, iss0, first;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checki(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Command expected for the t-th transaction since reset.
  function automatic logic [15:0] exp_cmd(input int t);
    logic [7:0] a;
    case (t)
      0: return 16'h0D02;
      1: return 16'h1062;
      2: return 16'h1162;
      3: return 16'h1460;
      default: begin
        a = 8'hA2 + 8'((t - 4) % 10);
        return {a, 8'h00};
      end
    endcase
  endfunction

  task automatic model_reset();
    issued = 0;
    delivered = 0;
    cnt = 0;
    mon_done = 1'b0;
    next_wrt_due = 0;
    last_done_cyc = -10;
    prev_wrt = 1'b0;
    last_cmd = 16'h0000;
    for (int i = 0; i < 5; i++) held[i] = 16'h0000;
  endtask

  // One clock cycle: observe and score DUT outputs, then play the monarch.
  task automatic step();
    int bi;
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    seen_wrt = wrt;
    seen_vld = vld;
    seen_cmd = cmd;

    checki("wrt_not_repeated", int'(prev_wrt & wrt), 0);
    if (wrt) begin
      checki("wrt_while_busy", int'(cnt != 0), 0);
      check($sformatf("cmd_tx%0d", issued), cmd, exp_cmd(issued));
      issued++;
      last_cmd = cmd;
    end else begin
      check("cmd_hold", cmd, last_cmd);
    end
    if (next_wrt_due == cyc) begin
      checki("wrt_after_done_gap", int'(wrt), 1);
      next_wrt_due = 0;
    end
    if (vld) begin
      checki("vld_after_tenth_done",
             int'(last_done_cyc == cyc - 1 && delivered >= 14 && (delivered - 4) % 10 == 0), 1);
      held[0] = {ret_b[1], ret_b[0]};
      held[1] = {ret_b[3], ret_b[2]};
      held[2] = {ret_b[5], ret_b[4]};
      held[3] = {ret_b[7], ret_b[6]};
      held[4] = {ret_b[9], ret_b[8]};
      vld_vals[0] = ptch; vld_vals[1] = roll; vld_vals[2] = yaw;
      vld_vals[3] = ax;   vld_vals[4] = ay;
    end
    check(vld ? "readings_on_vld" : "readings_held",
          {ptch, roll, yaw, ax, ay}, {held[0], held[1], held[2], held[3], held[4]});
    prev_wrt = wrt;

    mon_done = 1'b0;
    inert_data = 16'($urandom);
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mon_done = 1'b1;
        b = 8'($urandom);
        bi = int'(cur_addr) - 'hA2;
        if (bi >= 0 && bi < 10) begin
          b = rbytes[bi];
          ret_b[bi] = b;
        end
        inert_data = {8'($urandom), b};
        delivered++;
        last_done_cyc = cyc;
        if (delivered < 4 || (delivered > 4 && (delivered - 4) % 10 != 0))
          next_wrt_due = cyc + 1;
        if (cur_addr == 8'hA2 && autoclr) INT = 1'b0;
      end
    end
    if (wrt) begin
      cnt = lat;
      cur_addr = cmd[15:8];
      if (cmd[15:8] == 8'hA7 && reassert_on_yawh) INT = 1'b1;
    end
  endtask

  task automatic wait_wrt(input int budget, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!seen_wrt && k < budget);
    checki("wrt_arrives", int'(seen_wrt), 1);
  endtask

  task automatic wait_vld(input int budget, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!seen_vld && k < budget);
    checki("vld_arrives", int'(seen_vld), 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    checki({tag, "_wrt"}, int'(wrt), 0);
    checki({tag, "_vld"}, int'(vld), 0);
    check({tag, "_cmd"}, cmd, 16'h0000);
    check({tag, "_readings"}, {ptch, roll, yaw, ax, ay}, 80'h0);
  endtask

  initial begin
    vec[0] = '{80'hAA_99_88_77_66_55_44_33_22_11, 16'h2211, 16'h4433, 16'h6655, 16'h8877, 16'hAA99};
    vec[1] = '{80'h12_34_FF_FE_00_01_80_00_7F_FF, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFE, 16'h1234};
    vec[2] = '{80'hDD_EE_00_00_F0_0F_3C_C3_A5_5A, 16'hA55A, 16'h3CC3, 16'hF00F, 16'h0000, 16'hDDEE};

    rst = 1'b1; INT = 1'b1; stray_done = 1'b0; inert_data = 16'h0000;
    lat = 5; autoclr = 1'b1; reassert_on_yawh = 1'b0; cur_addr = 8'h00;
    for (int i = 0; i < 10; i++) begin
      rbytes[i] = 8'($urandom);
      ret_b[i] = 8'h00;
    end
    model_reset();

    // Reset held with INT high and done toggling.
    for (int i = 0; i < 6; i++) begin
      stray_done = i[0];
      step();
      check_zero_outputs("reset");
    end
    stray_done = 1'b0;
    INT = 1'b0;
    rst = 1'b0;
    model_reset();
    wait_wrt(100, n);
    checki("init_to_first_wrt", n, INIT_N + 1);

    // Configuration; INT raised before the last write completes.
    for (int k = 0; k < 300 && delivered < 3; k++) step();
    INT = 1'b1;
    for (int k = 0; k < 300 && delivered < 4; k++) step();
    checki("cfg_dones", delivered, 4);
    checki("cfg_wrt_count", issued, 4);
    c4 = last_done_cyc;
    wait_wrt(20, n);
    checki("cfg_end_to_first_read", cyc - c4, 2);
    wait_vld(300, n);

    // Table-driven bursts raised from IDLE.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) rbytes[i] = vec[r].bytes[8*i +: 8];
      lat = 2 + r;
      repeat (4) step();
      INT = 1'b1;
      wait_wrt(20, n);
      checki($sformatf("int_to_wrt_r%0d", r), n, 3);
      wait_vld(300, n);
      check($sformatf("ptch_r%0d", r), vld_vals[0], vec[r].e_ptch);
      check($sformatf("roll_r%0d", r), vld_vals[1], vec[r].e_roll);
      check($sformatf("yaw_r%0d", r),  vld_vals[2], vec[r].e_yaw);
      check($sformatf("ax_r%0d", r),   vld_vals[3], vec[r].e_ax);
      check($sformatf("ay_r%0d", r),   vld_vals[4], vec[r].e_ay);
    end

    // Back-to-back: INT drops on ptchL and comes back during yawH.
    for (int i = 0; i < 10; i++) rbytes[i] = 8'($urandom);
    lat = 3;
    reassert_on_yawh = 1'b1;
    repeat (3) step();
    iss0 = issued;
    INT = 1'b1;
    wait_vld(300, n);
    v1 = cyc;
    reassert_on_yawh = 1'b0;
    wait_wrt(20, n);
    checki("b2b_vld_to_next_wrt", cyc - v1, 2);
    wait_vld(300, n);
    checki("b2b_tx_count", issued - iss0, 20);
    checki("b2b_all_done", delivered, issued);

    // Randomized bursts, latencies, idle gaps and stray done in IDLE.
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 10; i++) rbytes[i] = 8'($urandom);
      lat = $urandom_range(1, 6);
      reassert_on_yawh = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 4)) step();
      INT = 1'b1;
      wait_vld(400, n);
      if (reassert_on_yawh) begin
        reassert_on_yawh = 1'b0;
        wait_vld(400, n);
      end
      repeat (2) step();
      stray_done = 1'b1;
      step();
      stray_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
        step();
        checki("stray_done_idle_no_wrt", int'(seen_wrt), 0);
      end
    end

    // Reset during the WAIT for axL.
    for (int i = 0; i < 10; i++) rbytes[i] = 8'($urandom);
    lat = 6;
    INT = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!(seen_wrt && seen_cmd == 16'hA800) && n < 300);
    check("reached_axL", seen_cmd, 16'hA800);
    repeat (2) step();
    rst = 1'b1;
    INT = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("async_rst");
    repeat (2) step();
    rst = 1'b0;
    model_reset();
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      stray_done = (k <= 12) && (k % 3 == 1);
      step();
      stray_done = 1'b0;
      if (seen_wrt) first = k;
    end
    checki("rst_restart_first_wrt", first, INIT_N + 1);
    for (int k = 0; k < 300 && delivered < 4; k++) step();
    checki("rst_restart_cfg_dones", delivered, 4);
    repeat (4) step();
    checki("rst_restart_no_read_without_int", issued, 4);
    for (int i = 0; i < 10; i++) rbytes[i] = vec[0].bytes[8*i +: 8];
    lat = 2;
    INT = 1'b1;
    wait_wrt(20, n);
    checki("rst_restart_int_to_wrt", n, 3);
    wait_vld(300, n);
    check("rst_restart_ptch", vld_vals[0], vec[0].e_ptch);
    check("rst_restart_ay", vld_vals[4], vec[0].e_ay);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
